// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder for the MEM stage.
// A request is accepted in IDLE, held for LATENCY wait cycles, and then
// committed to the word array on the edge that enters RESP. RESP presents a
// one-cycle response.
// Optional feature: define DMEM_MISALIGN_TRAP_EN to add the resp_err port.
// With it, a request whose address is not word aligned performs no array
// access and completes with resp_err = 1.
module dmem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        stall
`ifdef DMEM_MISALIGN_TRAP_EN
    ,
    output logic        resp_err
`endif
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          state;
    logic [3:0]      cnt;
    logic            wr_q;
    logic [AW-1:0]   idx_q;
    logic [31:0]     wdata_q;

    logic [31:0]     mem [DEPTH];

    logic            accept;
    logic            commit;
    logic            c_wr;
    logic            c_mis;
    logic [AW-1:0]   c_idx;
    logic [31:0]     c_wdata;
    logic [31:0]     rd_data;

    // Upper address bits only alias the array; addr[1:0] matters only with the trap.
    logic unused_addr;
    assign unused_addr = ^{req_addr[31:AW+2], req_addr[1:0]};

    assign accept = (state == IDLE) && req_valid;
    assign stall  = accept || (state == WAIT);
    // Commit happens on the edge that enters RESP.
    assign commit = (accept && (LATENCY == 0)) || ((state == WAIT) && (cnt == 4'd1));

`ifdef DMEM_MISALIGN_TRAP_EN
    logic mis_q;
    assign c_mis = (state == IDLE) ? (req_addr[1:0] != 2'b00) : mis_q;
`else
    assign c_mis = 1'b0;
`endif

    // Commit operands: live request with zero latency, captured copy otherwise.
    always_comb begin
        c_wr    = wr_q;
        c_idx   = idx_q;
        c_wdata = wdata_q;
        if (state == IDLE) begin
            c_wr    = req_write;
            c_idx   = req_addr[2 +: AW];
            c_wdata = req_wdata;
        end
        rd_data = (c_wr || c_mis) ? 32'h0 : mem[c_idx];
    end

    // Word array: no reset, and no write while reset is held.
    always_ff @(posedge clk) begin
        if (!rst && commit && c_wr && !c_mis)
            mem[c_idx] <= c_wdata;
    end

    // Control FSM with registered handshake and response outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            wr_q       <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= 32'h0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        wr_q      <= req_write;
                        idx_q     <= req_addr[2 +: AW];
                        wdata_q   <= req_wdata;
                        cnt       <= 4'(LATENCY);
                        req_ready <= 1'b0;
                        if (LATENCY == 0) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_rdata <= rd_data;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd1) begin
                        cnt        <= 4'd0;
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= rd_data;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    state      <= IDLE;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                    resp_rdata <= 32'h0;
                end
                default: begin
                    state      <= IDLE;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                    resp_rdata <= 32'h0;
                end
            endcase
        end
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    // Misalignment flag: captured at acceptance, shown during RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mis_q    <= 1'b0;
            resp_err <= 1'b0;
        end else begin
            if (accept)
                mis_q <= req_addr[1:0] != 2'b00;
            if (commit)
                resp_err <= c_mis;
            else if (state == RESP)
                resp_err <= 1'b0;
        end
    end
`endif

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Memory-side responder for data-memory accesses issued by the MEM pipeline stage. Accepts one load or store request at a time over a valid/ready handshake and holds it for a programmable wait latency. It then commits the access to an internal word array and returns a one-cycle response. It drives the stall that freezes the pipeline while an access is outstanding.

## Interface
Parameters:
- DEPTH, 256: number of 32-bit words in the array; power of two, ≥ 2.
- LATENCY, 2: wait cycles between acceptance and commit; legal range 0–15.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present from the MEM stage.
- req_write  input  1  1 = store, 0 = load; sampled at acceptance.
- req_addr  input  32  byte address; sampled at acceptance.
- req_wdata  input  32  store data; sampled at acceptance.
- req_ready  output  1  responder can accept a request this cycle.
- resp_valid  output  1  one-cycle pulse: access committed / load data valid.
- resp_rdata  output  32  load data, valid while resp_valid is high.
- stall  output  1  combinational; freezes the pipeline while a request is unserved.
- resp_err  output  1  misalignment error flag (present only with DMEM_MISALIGN_TRAP_EN).

## Operation
- States:
  - IDLE: req_ready = 1.
  - WAIT: req_ready = 0.
  - RESP: req_ready = 0.
- IDLE transitions:
  - On req_valid & req_ready: capture write, addr, wdata.
  - Load cnt = LATENCY.
  - Go to WAIT if LATENCY > 0, else go to RESP.
- WAIT: cnt decrements each cycle. When cnt == 1, go to RESP on the next edge.
- Commit happens on the edge entering RESP:
  - Store: mem[idx] <= wdata.
  - Load: resp_rdata <= mem[idx].
- Word index: idx = addr[2 +: log2(DEPTH)]. Upper address bits are ignored, so addresses wrap modulo DEPTH words. addr[1:0] is ignored unless the macro is enabled.
- RESP lasts exactly one cycle with resp_valid = 1, then returns to IDLE.
- For a store, resp_rdata holds 0 during RESP.
- stall = (IDLE & req_valid) | WAIT. It is low in RESP, so the pipeline advances in the same cycle load data is presented.
- req_* inputs are ignored outside the acceptance cycle. Changes mid-access have no effect.
- Array contents are not cleared by reset. Contents are undefined until written.

## Timing
- Reset values: state IDLE, req_ready 1, resp_valid 0, resp_rdata 0, resp_err 0, cnt 0. stall follows req_valid.
- Latency: acceptance at edge N, resp_valid high during cycle N+LATENCY+1.
- Throughput: one request per LATENCY+2 cycles. A new request is accepted only in IDLE, i.e. the cycle after RESP at the earliest.
- LATENCY = 0: acceptance edge goes directly to RESP; resp_valid appears in the next cycle.
- Reset asserted in WAIT: the access is dropped and a pending store is not committed.
- Reset asserted in RESP: the store has already committed and remains in the array; resp_valid is cleared.
- A store to X followed by a load from X returns the new data; there is no bypass hazard.

## Configuration
- DMEM_MISALIGN_TRAP_EN defined:
  - resp_err port exists.
  - A request with addr[1:0] != 0 performs no array access.
  - It completes with normal timing, with resp_valid = 1, resp_err = 1 and resp_rdata = 0.
  - resp_err is 0 for aligned requests.
- DMEM_MISALIGN_TRAP_EN undefined:
  - resp_err port is absent.
  - addr[1:0] is ignored and the access uses the word containing the address.

## Test plan
- Reset then idle: rst pulse, req_valid = 0 → req_ready = 1, resp_valid = 0, stall = 0, resp_rdata = 0.
- Store then load, LATENCY = 2:
  - Store 0xDEADBEEF to 0x10 → stall high for 3 cycles, resp_valid in cycle 3 after acceptance.
  - Load from 0x10 → resp_rdata = 0xDEADBEEF with resp_valid.
- Address wrap, DEPTH = 256:
  - Store 0x12345678 to 0x400; load from 0x000 → 0x12345678.
  - Load from 0x404 → value previously stored at 0x004.
- LATENCY = 0 back-to-back with req_valid held high → a response every 2 cycles; req_ready low in RESP cycles only.
- Reset mid-access: store 0xAAAA5555 to 0x20, assert rst in WAIT. After reset, a load of 0x20 returns the prior contents, not 0xAAAA5555.
- Macro enabled: load from 0x13 → resp_valid = 1, resp_err = 1, resp_rdata = 0. Array is unmodified when the same misalignment is applied to a store.
